cdb_arbiter: RTL and testbench

- Merges result broadcasts from the ALU reservation station (rss path) and the load/store buffer (lsb path) onto one common data bus (CDB).
- The CDB feeds the reorder buffer, the reservation stations and the issuer.
- Each source has a small FIFO so neither producer loses a result while the other holds the bus.
- Round-robin arbitration picks the source; a ROB reset flushes all pending results.

---
 rtl/cdb_arbiter_if.sv | 33 +++
 rtl/cdb_arbiter.sv | 136 +++++++++++++
 tb/tb_cdb_arbiter.sv | 249 ++++++++++++++++++++++++
 3 files changed

// File: rtl/cdb_arbiter_if.sv
// Producer/bus signal bundle for the common data bus arbiter.
// The slave modport is the arbiter's view; master is the environment's view.
interface cdb_arbiter_if #(
  parameter int ROB_ID_WIDTH = 5,
  parameter int DATA_WIDTH   = 32
);
  logic [ROB_ID_WIDTH-1:0] dest_from_rss;
  logic [DATA_WIDTH-1:0]   value_from_rss;
  logic [DATA_WIDTH-1:0]   next_pc_from_rss;
  logic [ROB_ID_WIDTH-1:0] dest_from_lsb;
  logic [DATA_WIDTH-1:0]   value_from_lsb;
  logic                    is_rss_fifo_full;
  logic                    is_lsb_fifo_full;
  logic [ROB_ID_WIDTH-1:0] dest_to_cdb;
  logic [DATA_WIDTH-1:0]   value_to_cdb;
  logic [DATA_WIDTH-1:0]   next_pc_to_cdb;
  logic                    src_to_cdb;
  logic                    overflow;

  modport slave (
    input  dest_from_rss, value_from_rss, next_pc_from_rss,
    input  dest_from_lsb, value_from_lsb,
    output is_rss_fifo_full, is_lsb_fifo_full,
    output dest_to_cdb, value_to_cdb, next_pc_to_cdb, src_to_cdb, overflow
  );

  modport master (
    output dest_from_rss, value_from_rss, next_pc_from_rss,
    output dest_from_lsb, value_from_lsb,
    input  is_rss_fifo_full, is_lsb_fifo_full,
    input  dest_to_cdb, value_to_cdb, next_pc_to_cdb, src_to_cdb, overflow
  );
endinterface

// File: rtl/cdb_arbiter.sv
// Merges ALU (rss) and load/store (lsb) results onto one CDB through
// per-source FIFOs with round-robin arbitration and a ROB-driven flush.
module cdb_arbiter #(
  parameter int ROB_ID_WIDTH = 5,
  parameter int DATA_WIDTH   = 32,
  parameter int FIFO_DEPTH   = 4
) (
  input logic          clk,
  input logic          rst,
  input logic          rdy,
  input logic          reset_from_rob_bus,
  cdb_arbiter_if.slave bus
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic {
    GRANT_ALU = 1'b0,
    GRANT_LSB = 1'b1
  } grant_t;

  logic [ROB_ID_WIDTH-1:0] rss_dest_mem [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0]   rss_val_mem  [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0]   rss_pc_mem   [FIFO_DEPTH];
  logic [ROB_ID_WIDTH-1:0] lsb_dest_mem [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0]   lsb_val_mem  [FIFO_DEPTH];

  logic [PW-1:0] rss_head, rss_tail, lsb_head, lsb_tail;
  logic [CW-1:0] rss_count, lsb_count;
  grant_t        last_grant;

  logic [ROB_ID_WIDTH-1:0] dest_q;
  logic [DATA_WIDTH-1:0]   value_q;
  logic [DATA_WIDTH-1:0]   next_pc_q;
  logic                    src_q;
  logic                    overflow_q;

  logic advance;
  logic pop_rss, pop_lsb;
  logic rss_wr, lsb_wr, rss_ovf, lsb_ovf;
  logic rss_at_cap, lsb_at_cap;

  always_comb begin
    advance    = rdy && !reset_from_rob_bus;
    pop_rss    = (rss_count != '0) && ((lsb_count == '0) || (last_grant == GRANT_LSB));
    pop_lsb    = (lsb_count != '0) && !pop_rss;
    rss_at_cap = (rss_count == CW'(FIFO_DEPTH));
    lsb_at_cap = (lsb_count == CW'(FIFO_DEPTH));
    // A full FIFO that pops this edge frees the slot the push needs.
    rss_wr     = (bus.dest_from_rss != '0) && (!rss_at_cap || pop_rss);
    lsb_wr     = (bus.dest_from_lsb != '0) && (!lsb_at_cap || pop_lsb);
    rss_ovf    = (bus.dest_from_rss != '0) && rss_at_cap && !pop_rss;
    lsb_ovf    = (bus.dest_from_lsb != '0) && lsb_at_cap && !pop_lsb;
  end

  // Storage carries no reset; validity is tracked solely by the counts.
  always_ff @(posedge clk) begin
    if (advance && rss_wr) begin
      rss_dest_mem[rss_tail] <= bus.dest_from_rss;
      rss_val_mem[rss_tail]  <= bus.value_from_rss;
      rss_pc_mem[rss_tail]   <= bus.next_pc_from_rss;
    end
    if (advance && lsb_wr) begin
      lsb_dest_mem[lsb_tail] <= bus.dest_from_lsb;
      lsb_val_mem[lsb_tail]  <= bus.value_from_lsb;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rss_head   <= '0;
      rss_tail   <= '0;
      rss_count  <= '0;
      lsb_head   <= '0;
      lsb_tail   <= '0;
      lsb_count  <= '0;
      last_grant <= GRANT_LSB;
      dest_q     <= '0;
      value_q    <= '0;
      next_pc_q  <= '0;
      src_q      <= 1'b0;
      overflow_q <= 1'b0;
    end else if (rdy) begin
      if (reset_from_rob_bus) begin
        rss_head   <= '0;
        rss_tail   <= '0;
        rss_count  <= '0;
        lsb_head   <= '0;
        lsb_tail   <= '0;
        lsb_count  <= '0;
        last_grant <= GRANT_LSB;
        dest_q     <= '0;
        value_q    <= '0;
        next_pc_q  <= '0;
        src_q      <= 1'b0;
      end else begin
        if (rss_wr)  rss_tail <= rss_tail + 1'b1;
        if (pop_rss) rss_head <= rss_head + 1'b1;
        if (lsb_wr)  lsb_tail <= lsb_tail + 1'b1;
        if (pop_lsb) lsb_head <= lsb_head + 1'b1;
        rss_count <= rss_count + CW'(rss_wr) - CW'(pop_rss);
        lsb_count <= lsb_count + CW'(lsb_wr) - CW'(pop_lsb);
        if (rss_ovf || lsb_ovf) overflow_q <= 1'b1;

        if (pop_rss) begin
          dest_q     <= rss_dest_mem[rss_head];
          value_q    <= rss_val_mem[rss_head];
          next_pc_q  <= rss_pc_mem[rss_head];
          src_q      <= 1'b0;
          last_grant <= GRANT_ALU;
        end else if (pop_lsb) begin
          dest_q     <= lsb_dest_mem[lsb_head];
          value_q    <= lsb_val_mem[lsb_head];
          next_pc_q  <= '0;
          src_q      <= 1'b1;
          last_grant <= GRANT_LSB;
        end else begin
          dest_q    <= '0;
          value_q   <= '0;
          next_pc_q <= '0;
          src_q     <= 1'b0;
        end
      end
    end
  end

  assign bus.is_rss_fifo_full = (rss_count >= CW'(FIFO_DEPTH - 1));
  assign bus.is_lsb_fifo_full = (lsb_count >= CW'(FIFO_DEPTH - 1));
  assign bus.dest_to_cdb      = dest_q;
  assign bus.value_to_cdb     = value_q;
  assign bus.next_pc_to_cdb   = next_pc_q;
  assign bus.src_to_cdb       = src_q;
  assign bus.overflow         = overflow_q;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Randomized and directed bench for cdb_arbiter against a queue-based model
// of the two result FIFOs and the round-robin bus grant.
module tb_cdb_arbiter;
  localparam int RW    = 5;
  localparam int DW    = 32;
  localparam int DEPTH = 4;

  typedef struct {
    logic [RW-1:0] d;
    logic [DW-1:0] v;
    logic [DW-1:0] pc;
    logic          s;
  } ent_t;

  logic clk = 1'b0;
  logic rst, rdy, flush;

  cdb_arbiter_if #(.ROB_ID_WIDTH(RW), .DATA_WIDTH(DW)) bus ();

  cdb_arbiter #(.ROB_ID_WIDTH(RW), .DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH)) dut (
    .clk                (clk),
    .rst                (rst),
    .rdy                (rdy),
    .reset_from_rob_bus (flush),
    .bus                (bus)
  );

  always #5 clk = ~clk;

  int   tests = 0;
  int   fails = 0;
  ent_t rq[$];
  ent_t lq[$];
  int   last_src;
  ent_t exp_out;
  bit   exp_ovf;

  function automatic ent_t mk(int d, int v, int pc, bit s);
    ent_t e;
    e.d = RW'(d); e.v = DW'(v); e.pc = DW'(pc); e.s = s;
    return e;
  endfunction

  function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endfunction

  function automatic void model_reset();
    rq.delete();
    lq.delete();
    last_src = 1;
    exp_out  = mk(0, 0, 0, 0);
    exp_ovf  = 0;
  endfunction

  // Pop is decided on the pre-edge occupancy, so popping before pushing
  // lets a full queue take a new entry on the same edge.
  function automatic void model_edge(ent_t r_in, ent_t l_in, bit r_rdy, bit f);
    ent_t l_ent;
    if (!r_rdy) return;
    if (f) begin
      rq.delete();
      lq.delete();
      last_src = 1;
      exp_out  = mk(0, 0, 0, 0);
      return;
    end
    if (rq.size() > 0 && (lq.size() == 0 || last_src == 1)) begin
      exp_out  = rq.pop_front();
      last_src = 0;
    end else if (lq.size() > 0) begin
      exp_out  = lq.pop_front();
      last_src = 1;
    end else begin
      exp_out = mk(0, 0, 0, 0);
    end
    if (r_in.d != 0) begin
      if (rq.size() < DEPTH) rq.push_back(mk(int'(r_in.d), int'(r_in.v), int'(r_in.pc), 0));
      else exp_ovf = 1;
    end
    if (l_in.d != 0) begin
      l_ent = mk(int'(l_in.d), int'(l_in.v), 0, 1);
      if (lq.size() < DEPTH) lq.push_back(l_ent);
      else exp_ovf = 1;
    end
  endfunction

  function automatic void compare_all();
    chk("dest",     64'(bus.dest_to_cdb),      64'(exp_out.d));
    chk("value",    64'(bus.value_to_cdb),     64'(exp_out.v));
    chk("next_pc",  64'(bus.next_pc_to_cdb),   64'(exp_out.pc));
    chk("src",      64'(bus.src_to_cdb),       64'(exp_out.s));
    chk("overflow", 64'(bus.overflow),         64'(exp_ovf));
    chk("rss_full", 64'(bus.is_rss_fifo_full), 64'(rq.size() >= DEPTH - 1));
    chk("lsb_full", 64'(bus.is_lsb_fifo_full), 64'(lq.size() >= DEPTH - 1));
  endfunction

  task automatic drive(ent_t r_in, ent_t l_in, bit r_rdy, bit f);
    bus.dest_from_rss    = r_in.d;
    bus.value_from_rss   = r_in.v;
    bus.next_pc_from_rss = r_in.pc;
    bus.dest_from_lsb    = l_in.d;
    bus.value_from_lsb   = l_in.v;
    rdy   = r_rdy;
    flush = f;
    @(posedge clk);
    model_edge(r_in, l_in, r_rdy, f);
    #1;
    compare_all();
  endtask

  task automatic idle();
    drive(mk(0, 0, 0, 0), mk(0, 0, 0, 0), 1'b1, 1'b0);
  endtask

  // Reset asserted between edges must clear outputs without a clock.
  task automatic async_reset();
    #2;
    rst = 1'b0;
    #1;
    model_reset();
    compare_all();
    chk("async_dest_zero", 64'(bus.dest_to_cdb), 64'd0);
    chk("async_ovf_zero",  64'(bus.overflow),    64'd0);
    #1;
    rst = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit expired");
    $fatal(1, "timeout");
  end

  initial begin
    int   seq [8];
    bit   saw9;
    ent_t n;
    seq = '{1, 9, 2, 10, 3, 11, 4, 12};
    n = mk(0, 0, 0, 0);
    rst = 1'b0; rdy = 1'b1; flush = 1'b0;
    bus.dest_from_rss = '0; bus.value_from_rss = '0; bus.next_pc_from_rss = '0;
    bus.dest_from_lsb = '0; bus.value_from_lsb = '0;
    model_reset();
    #12;
    compare_all();
    chk("reset_dest", 64'(bus.dest_to_cdb), 64'd0);
    chk("reset_full", 64'(bus.is_rss_fifo_full), 64'd0);
    rst = 1'b1;

    // Single ALU push: two edges input-to-bus, one-cycle broadcast.
    drive(mk(3, 'h10, 'h104, 0), n, 1'b1, 1'b0);
    chk("single_latency", 64'(bus.dest_to_cdb), 64'd0);
    idle();
    chk("single_dest", 64'(bus.dest_to_cdb),    64'd3);
    chk("single_val",  64'(bus.value_to_cdb),   64'h10);
    chk("single_pc",   64'(bus.next_pc_to_cdb), 64'h104);
    chk("single_src",  64'(bus.src_to_cdb),     64'd0);
    idle();
    chk("single_gone", 64'(bus.dest_to_cdb), 64'd0);

    // Contention right after reset: ALU first, twice.
    async_reset();
    for (int rep = 0; rep < 2; rep++) begin
      drive(mk(2, 'h20, 'h200, 0), mk(5, 'h50, 0, 1), 1'b1, 1'b0);
      idle();
      chk("cont_first",     64'(bus.dest_to_cdb), 64'd2);
      chk("cont_first_src", 64'(bus.src_to_cdb),  64'd0);
      idle();
      chk("cont_second",     64'(bus.dest_to_cdb), 64'd5);
      chk("cont_second_src", 64'(bus.src_to_cdb),  64'd1);
      chk("cont_lsb_pc",     64'(bus.next_pc_to_cdb), 64'd0);
      idle();
      chk("cont_idle", 64'(bus.dest_to_cdb), 64'd0);
    end

    // Steady contention alternates strictly.
    for (int j = 0; j < 9; j++) begin
      if (j < 4) drive(mk(1 + j, 'h100 + j, 'h400 + j, 0), mk(9 + j, 'h900 + j, 0, 1), 1'b1, 1'b0);
      else idle();
      if (j >= 1) chk("steady_seq", 64'(bus.dest_to_cdb), 64'(seq[j-1]));
    end
    idle();

    // Pre-full and overflow on the rss FIFO while the lsb side competes.
    async_reset();
    for (int i = 1; i <= 9; i++) begin
      drive(mk(i, 'hA0 + i, 'hB0 + i, 0), (i <= 7) ? mk(16 + i, 'hC0 + i, 0, 1) : n, 1'b1, 1'b0);
      if (i == 4) chk("prefull_below", 64'(bus.is_rss_fifo_full), 64'd0);
      if (i == 5) chk("prefull_at3",   64'(bus.is_rss_fifo_full), 64'd1);
      if (i == 8) chk("full_pop_push", 64'(bus.overflow), 64'd0);
      if (i == 9) chk("overflow_set",  64'(bus.overflow), 64'd1);
    end
    saw9 = 0;
    for (int i = 0; i < 14; i++) begin
      idle();
      if (bus.dest_to_cdb == RW'(9) && bus.src_to_cdb == 1'b0) saw9 = 1;
    end
    chk("dropped_tag_absent", 64'(saw9), 64'd0);
    chk("overflow_sticky", 64'(bus.overflow), 64'd1);

    // Flush mid-stream with a push on the flush edge.
    async_reset();
    for (int i = 0; i < 5; i++) drive(mk(1 + i, i, i, 0), mk(17 + i, i, 0, 1), 1'b1, 1'b0);
    drive(mk(30, 1, 1, 0), mk(31, 1, 0, 1), 1'b1, 1'b1);
    chk("flush_dest",     64'(bus.dest_to_cdb),      64'd0);
    chk("flush_rss_full", 64'(bus.is_rss_fifo_full), 64'd0);
    chk("flush_lsb_full", 64'(bus.is_lsb_fifo_full), 64'd0);
    for (int i = 0; i < 6; i++) begin
      idle();
      chk("flush_quiet", 64'(bus.dest_to_cdb), 64'd0);
    end

    // rdy low holds the bus and ignores pushes.
    drive(mk(7, 'h77, 'h700, 0), n, 1'b1, 1'b0);
    idle();
    chk("rdy_pre", 64'(bus.dest_to_cdb), 64'd7);
    for (int i = 0; i < 3; i++) begin
      drive(mk(8, 'h88, 'h800, 0), mk(9, 'h99, 0, 1), 1'b0, 1'b0);
      chk("rdy_hold_dest", 64'(bus.dest_to_cdb),  64'd7);
      chk("rdy_hold_val",  64'(bus.value_to_cdb), 64'h77);
    end
    idle();
    chk("rdy_no_push", 64'(bus.dest_to_cdb), 64'd0);

    // Randomized traffic.
    for (int c = 0; c < 3000; c++) begin
      ent_t r_in, l_in;
      bit   r_rdy, f;
      r_in  = n;
      l_in  = n;
      r_rdy = ($urandom_range(0, 9) != 0);
      f     = ($urandom_range(0, 49) == 0);
      if ($urandom_range(0, 9) < 6 && (!bus.is_rss_fifo_full || $urandom_range(0, 4) == 0))
        r_in = mk($urandom_range(1, 31), $urandom, $urandom, 0);
      if ($urandom_range(0, 9) < 6 && (!bus.is_lsb_fifo_full || $urandom_range(0, 4) == 0))
        l_in = mk($urandom_range(1, 31), $urandom, 0, 1);
      drive(r_in, l_in, r_rdy, f);
      if ($urandom_range(0, 199) == 0) async_reset();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
